// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receiver.
// Scan codes are PS/2 set 2.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_e;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ASCII_W = 7;

  localparam logic [BYTE_W-1:0] SC_EXT    = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_BRK    = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [BYTE_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [BYTE_W-1:0] SC_ENTER  = 8'h5A;
  localparam logic [BYTE_W-1:0] SC_BKSP   = 8'h66;
  localparam logic [BYTE_W-1:0] SC_SPACE  = 8'h29;

  // Selects the shifted or unshifted character of a key.
  function automatic logic [ASCII_W-1:0] pick(input logic sh,
                                              input logic [BYTE_W-1:0] lo,
                                              input logic [BYTE_W-1:0] hi);
    return sh ? ASCII_W'(hi) : ASCII_W'(lo);
  endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational set-2 scan-code to 7-bit ASCII map for a US layout.
// hit_c is low for codes that produce no character.
module ps2_scan_to_ascii
  import ps2_pkg::*;
(
  input  logic [BYTE_W-1:0]  scancode,
  input  logic               shift,
  output logic               hit_c,
  output logic [ASCII_W-1:0] ascii_c
);

  always_comb begin
    hit_c   = 1'b1;
    ascii_c = '0;
    case (scancode)
      8'h1C: ascii_c = pick(shift, "a", "A");
      8'h32: ascii_c = pick(shift, "b", "B");
      8'h21: ascii_c = pick(shift, "c", "C");
      8'h23: ascii_c = pick(shift, "d", "D");
      8'h24: ascii_c = pick(shift, "e", "E");
      8'h2B: ascii_c = pick(shift, "f", "F");
      8'h34: ascii_c = pick(shift, "g", "G");
      8'h33: ascii_c = pick(shift, "h", "H");
      8'h43: ascii_c = pick(shift, "i", "I");
      8'h3B: ascii_c = pick(shift, "j", "J");
      8'h42: ascii_c = pick(shift, "k", "K");
      8'h4B: ascii_c = pick(shift, "l", "L");
      8'h3A: ascii_c = pick(shift, "m", "M");
      8'h31: ascii_c = pick(shift, "n", "N");
      8'h44: ascii_c = pick(shift, "o", "O");
      8'h4D: ascii_c = pick(shift, "p", "P");
      8'h15: ascii_c = pick(shift, "q", "Q");
      8'h2D: ascii_c = pick(shift, "r", "R");
      8'h1B: ascii_c = pick(shift, "s", "S");
      8'h2C: ascii_c = pick(shift, "t", "T");
      8'h3C: ascii_c = pick(shift, "u", "U");
      8'h2A: ascii_c = pick(shift, "v", "V");
      8'h1D: ascii_c = pick(shift, "w", "W");
      8'h22: ascii_c = pick(shift, "x", "X");
      8'h35: ascii_c = pick(shift, "y", "Y");
      8'h1A: ascii_c = pick(shift, "z", "Z");
      // Digit row
      8'h16: ascii_c = pick(shift, "1", "!");
      8'h1E: ascii_c = pick(shift, "2", "@");
      8'h26: ascii_c = pick(shift, "3", "#");
      8'h25: ascii_c = pick(shift, "4", "$");
      8'h2E: ascii_c = pick(shift, "5", "%");
      8'h36: ascii_c = pick(shift, "6", "^");
      8'h3D: ascii_c = pick(shift, "7", "&");
      8'h3E: ascii_c = pick(shift, "8", "*");
      8'h46: ascii_c = pick(shift, "9", "(");
      8'h45: ascii_c = pick(shift, "0", ")");
      // Punctuation
      8'h4E: ascii_c = pick(shift, "-", "_");
      8'h55: ascii_c = pick(shift, "=", "+");
      8'h54: ascii_c = pick(shift, "[", "{");
      8'h5B: ascii_c = pick(shift, "]", "}");
      8'h4C: ascii_c = pick(shift, ";", ":");
      8'h52: ascii_c = pick(shift, "'", "\"");
      8'h41: ascii_c = pick(shift, ",", "<");
      8'h49: ascii_c = pick(shift, ".", ">");
      8'h4A: ascii_c = pick(shift, "/", "?");
      SC_SPACE: ascii_c = 7'h20;
      SC_ENTER: ascii_c = 7'h0D;
      SC_BKSP:  ascii_c = 7'h08;
      default:  hit_c   = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes the PS/2 lines, deframes 11-bit frames
// and turns make/break/extended scan codes into one-cycle ASCII strobes.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ps2_clk,
  input  logic               ps2_dat,
  output logic [ASCII_W-1:0] ascii,
  output logic               ascii_valid,
  output logic [BYTE_W-1:0]  scancode,
  output logic               scan_valid,
  output logic               frame_err,
  output logic               shift
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned BIT_W = 3;

  // Line synchronizers; idle-high reset so a release never fakes an edge
  logic clk_s1, clk_s2, clk_h;
  logic dat_s1, dat_s2;
  logic fall_q, dat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_h  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      fall_q <= 1'b0;
      dat_q  <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_h  <= clk_s2;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
      fall_q <= clk_h & ~clk_s2;
      dat_q  <= dat_s2;
    end
  end

  // Frame FSM
  frame_state_e      state_q, state_d;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              byte_ok_q, byte_ok_d;
  logic              byte_err_q, byte_err_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              tmo_c;

  assign tmo_c = (cnt_q == CNT_W'(TIMEOUT)) && (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      byte_ok_q  <= 1'b0;
      byte_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      byte_ok_q  <= byte_ok_d;
      byte_err_q <= byte_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    byte_ok_d  = 1'b0;
    byte_err_d = 1'b0;
    if (tmo_c) begin
      state_d = IDLE;
    end else if (fall_q) begin
      case (state_q)
        IDLE: begin
          if (!dat_q) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shreg_d  = {dat_q, shreg_q[BYTE_W-1:1]};
          bitcnt_d = bitcnt_q + BIT_W'(1);
          if (bitcnt_q == BIT_W'(BYTE_W - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_q && (^{shreg_q, par_q})) byte_ok_d = 1'b1;
          else                              byte_err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating idle counter, cleared by every ps2_clk falling edge
  always_ff @(posedge clk) begin
    if (reset)                          cnt_q <= '0;
    else if (fall_q)                    cnt_q <= '0;
    else if (cnt_q != CNT_W'(TIMEOUT))  cnt_q <= cnt_q + CNT_W'(1);
  end

  // Prefix/shift tracker and key lookup, one cycle after a good byte
  logic               ext_q, brk_q;
  logic               key_hit_q;
  logic [ASCII_W-1:0] key_ascii_q;
  logic               hit_c;
  logic [ASCII_W-1:0] ascii_c;
  logic               is_shift_c;

  assign is_shift_c = (shreg_q == SC_LSHIFT) || (shreg_q == SC_RSHIFT);

  ps2_scan_to_ascii u_map (
    .scancode (shreg_q),
    .shift    (shift),
    .hit_c    (hit_c),
    .ascii_c  (ascii_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      shift       <= 1'b0;
      key_hit_q   <= 1'b0;
      key_ascii_q <= '0;
    end else begin
      key_hit_q <= 1'b0;
      if (byte_ok_q) begin
        if (shreg_q == SC_EXT) begin
          ext_q <= 1'b1;
        end else if (shreg_q == SC_BRK) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (!ext_q && is_shift_c) shift <= ~brk_q;
          key_hit_q   <= ~ext_q & ~brk_q & ~is_shift_c & hit_c;
          key_ascii_q <= ascii_c;
        end
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_valid  <= 1'b0;
      scancode    <= '0;
      frame_err   <= 1'b0;
      ascii_valid <= 1'b0;
      ascii       <= '0;
    end else begin
      scan_valid  <= byte_ok_q;
      frame_err   <= byte_err_q | tmo_c;
      ascii_valid <= key_hit_q;
      if (byte_ok_q) scancode <= shreg_q;
      if (key_hit_q) ascii    <= key_ascii_q;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed scenarios plus random
// key streams compared against a table-driven keyboard model.
module tb_ps2_keyboard_rx;

  localparam int unsigned TMO  = 200;
  localparam int          HALF = 20;

  logic       clk = 1'b0;
  logic       reset, ps2_clk, ps2_dat;
  logic [6:0] ascii;
  logic       ascii_valid;
  logic [7:0] scancode;
  logic       scan_valid, frame_err, shift;

  int passed = 0;
  int fails  = 0;

  ps2_keyboard_rx #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .ascii       (ascii),
    .ascii_valid (ascii_valid),
    .scancode    (scancode),
    .scan_valid  (scan_valid),
    .frame_err   (frame_err),
    .shift       (shift)
  );

  always #5 clk = ~clk;

  // Keyboard model: US layout as character strings indexed alongside scan codes
  string      letters   = "abcdefghijklmnopqrstuvwxyz";
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  string      plain_sym = "1234567890-=[];',./";
  string      shift_sym = "!@#$%^&*()_+{}:\"<>?";
  logic [7:0] sym_sc [19] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'h54, 8'h5B,
                              8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  logic [7:0] misc_sc [10] = '{8'h12, 8'h59, 8'hE0, 8'hF0, 8'h29, 8'h5A, 8'h66,
                               8'h05, 8'h76, 8'h75};

  logic m_ext = 1'b0, m_brk = 1'b0, m_shift = 1'b0;

  task automatic lookup(input logic [7:0] b, input logic sh,
                        output logic hit, output logic [6:0] a);
    hit = 1'b0;
    a   = '0;
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == b) begin
        hit = 1'b1;
        a   = 7'(letters[i] - (sh ? 8'd32 : 8'd0));
      end
    for (int i = 0; i < 19; i++)
      if (sym_sc[i] == b) begin
        hit = 1'b1;
        a   = sh ? 7'(shift_sym[i]) : 7'(plain_sym[i]);
      end
    if (b == 8'h29) begin hit = 1'b1; a = 7'h20; end
    if (b == 8'h5A) begin hit = 1'b1; a = 7'h0D; end
    if (b == 8'h66) begin hit = 1'b1; a = 7'h08; end
  endtask

  task automatic model_byte(input logic [7:0] b, output logic hit, output logic [6:0] a);
    hit = 1'b0;
    a   = '0;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = !m_brk;
      else if (!m_ext && !m_brk) lookup(b, m_shift, hit, a);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full PS/2 clock pulse carrying bit b
  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_dat = b;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
  endtask

  // Start, data, parity, then the stop bit's falling edge (clock left low)
  task automatic send_head(input logic [7:0] b, input logic flip);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ flip);
    @(negedge clk);
    ps2_dat = 1'b1;
    wait_clks(HALF);
    ps2_clk = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input logic flip);
    logic       hit;
    logic [6:0] a, asc;
    logic [7:0] sc;
    int         sv_n, sv_at, fe_n, fe_at, av_n, av_at;
    string      t;
    t = $sformatf("%s/%02h", tag, b);
    hit = 1'b0;
    a   = '0;
    if (!flip) model_byte(b, hit, a);
    send_head(b, flip);
    sv_n = 0; fe_n = 0; av_n = 0;
    sv_at = -1; fe_at = -1; av_at = -1;
    sc = '0; asc = '0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (scan_valid)  begin sv_n++; sv_at = k; sc  = scancode; end
      if (frame_err)   begin fe_n++; fe_at = k; end
      if (ascii_valid) begin av_n++; av_at = k; asc = ascii;    end
    end
    wait_clks(HALF);
    ps2_clk = 1'b1;
    wait_clks(HALF);
    check({t, " scan_valid count"}, 32'(sv_n), flip ? 32'd0 : 32'd1);
    if (!flip) begin
      check({t, " scan_valid latency"}, 32'(sv_at), 32'd4);
      check({t, " scancode"}, 32'(sc), 32'(b));
    end
    check({t, " frame_err count"}, 32'(fe_n), flip ? 32'd1 : 32'd0);
    if (flip) check({t, " frame_err latency"}, 32'(fe_at), 32'd4);
    check({t, " ascii_valid count"}, 32'(av_n), hit ? 32'd1 : 32'd0);
    if (hit) begin
      check({t, " ascii_valid latency"}, 32'(av_at), 32'd5);
      check({t, " ascii"}, 32'(asc), 32'(a));
    end
    check({t, " shift"}, 32'(shift), 32'(m_shift));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({ascii, ascii_valid, scancode, scan_valid, frame_err, shift}), 32'd0);
  endtask

  initial begin
    int         fe_n, sv_n, r;
    logic [7:0] b;
    reset   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset outputs");
    @(negedge clk);
    reset = 1'b0;
    wait_clks(10);
    check_all_zero("idle after reset");

    run_frame("a", 8'h1C, 1'b0);

    run_frame("shift", 8'h12, 1'b0);
    run_frame("A",     8'h1C, 1'b0);
    run_frame("brk",   8'hF0, 1'b0);
    run_frame("a-up",  8'h1C, 1'b0);
    run_frame("brk",   8'hF0, 1'b0);
    run_frame("unshf", 8'h12, 1'b0);
    run_frame("a",     8'h1C, 1'b0);

    run_frame("parity err", 8'h1C, 1'b1);
    run_frame("after err",  8'h1C, 1'b0);

    // Partial frame followed by a ps2_clk stall beyond the timeout
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    fe_n = 0;
    sv_n = 0;
    for (int k = 0; k < 3 * int'(TMO); k++) begin
      @(posedge clk); #1;
      if (frame_err)  fe_n++;
      if (scan_valid) sv_n++;
    end
    check("timeout frame_err count", 32'(fe_n), 32'd1);
    check("timeout scan_valid count", 32'(sv_n), 32'd0);
    run_frame("space", 8'h29, 1'b0);

    run_frame("ext",     8'hE0, 1'b0);
    run_frame("ext key", 8'h75, 1'b0);
    run_frame("ext",     8'hE0, 1'b0);
    run_frame("ext brk", 8'hF0, 1'b0);
    run_frame("ext key", 8'h75, 1'b0);

    // Reset in the middle of a frame while shift is held
    run_frame("shift", 8'h59, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
    @(negedge clk);
    reset   = 1'b1;
    m_ext   = 1'b0;
    m_brk   = 1'b0;
    m_shift = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_all_zero($sformatf("in reset %0d", k));
    end
    @(negedge clk);
    reset = 1'b0;
    wait_clks(10);
    check_all_zero("after mid-frame reset");
    run_frame("enter", 8'h5A, 1'b0);

    // Random key streams
    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(0, 2));
      if (r == 0)      b = letter_sc[$urandom_range(0, 25)];
      else if (r == 1) b = sym_sc[$urandom_range(0, 18)];
      else             b = misc_sc[$urandom_range(0, 9)];
      run_frame($sformatf("rnd%0d", n), b, $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", passed, passed + fails);
    $finish;
  end

endmodule
